// File: rtl/i2c_cfg_pkg.sv
// rtl/i2c_cfg_pkg.sv - shared types and constants for the I2C config sequencer
//
// Purpose: sequencer state encoding, table entry layout (7-bit device address,
// 8-bit sub-address, 8-bit data = 23 bits) and the fixed master transfer length.
// Ports: none (package).

package i2c_cfg_pkg;

   typedef enum logic [3:0] {
      ST_PWR,
      ST_LOAD,
      ST_WREQ,
      ST_WBUSY,
      ST_RREQ,
      ST_RBUSY,
      ST_CHECK,
      ST_NEXT,
      ST_GAP,
      ST_DONE
   } cfg_state_t;

   localparam int ADDR_W  = 7;
   localparam int SUB_W   = 8;
   localparam int DATA_W  = 8;
   localparam int ENTRY_W = ADDR_W + SUB_W + DATA_W;

   // The master is only ever asked for single-byte transfers.
   localparam logic [7:0] XFER_LEN = 8'd1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [SUB_W-1:0]  sub;
      logic [DATA_W-1:0] data;
   } cfg_entry_t;

endpackage

// File: rtl/i2c_config_rom.sv
// rtl/i2c_config_rom.sv - board-specific register initialisation table
//
// Purpose: combinational lookup of one {addr7, sub8, data8} entry by index.
// Indices at or beyond ENTRIES read as all-zero.
// Ports:
//   index  in  8   table index
//   entry  out 23  {device address, sub-address, data}

module i2c_config_rom
   import i2c_cfg_pkg::*;
#(
   parameter int ENTRIES = 16
) (
   input  logic [7:0] index,
   output cfg_entry_t entry
);

   always_comb begin
      entry = '0;
      if ({24'd0, index} < ENTRIES) begin
         case (index)
            // Audio codec (7'h1A)
            8'd0:    entry = {7'h1A, 8'h1E, 8'h00};
            8'd1:    entry = {7'h1A, 8'h01, 8'h3C};
            8'd2:    entry = {7'h1A, 8'h04, 8'h12};
            8'd3:    entry = {7'h1A, 8'h08, 8'h15};
            8'd4:    entry = {7'h1A, 8'h0A, 8'h06};
            8'd5:    entry = {7'h1A, 8'h0C, 8'h00};
            8'd6:    entry = {7'h1A, 8'h0E, 8'h42};
            8'd7:    entry = {7'h1A, 8'h10, 8'h02};
            8'd8:    entry = {7'h1A, 8'h12, 8'h01};
            // Video decoder (7'h20)
            8'd9:    entry = {7'h20, 8'h00, 8'h04};
            8'd10:   entry = {7'h20, 8'h04, 8'h57};
            8'd11:   entry = {7'h20, 8'h31, 8'h02};
            8'd12:   entry = {7'h20, 8'h3D, 8'hA2};
            8'd13:   entry = {7'h20, 8'h3E, 8'h6A};
            8'd14:   entry = {7'h20, 8'h3F, 8'hA0};
            8'd15:   entry = {7'h20, 8'h0E, 8'h80};
            default: entry = '0;
         endcase
      end
   end

endmodule

// File: rtl/i2c_config_sequencer.sv
// rtl/i2c_config_sequencer.sv - power-up I2C register initialisation sequencer
//
// Purpose: walks the config table, issuing one master write per entry (plus an
// optional read-back compare with bounded retries), then reports done/error.
// Ports:
//   clk_50       in  1  system clock
//   rst_n        in  1  asynchronous active-low reset
//   start        in  1  re-run pulse, honoured only in DONE
//   done         out 1  table finished; cleared by start
//   error        out 1  sticky timeout / retry-exhausted flag; cleared by start
//   err_index    out 8  index of first failing entry
//   request      out 1  master transfer request
//   WR           out 1  1 = write, 0 = read
//   length       out 8  transfer length (always 1)
//   address      out 7  device address
//   sub_address  out 8  register address
//   txReg        out 8  write data
//   busy         in  1  master busy (clk_50 synchronous)
//   rxReg        in  8  master read data

module i2c_config_sequencer
   import i2c_cfg_pkg::*;
#(
   parameter int ENTRIES      = 16,
   parameter int PWR_WAIT     = 2_500_000,
   parameter int GAP_CYCLES   = 1024,
   parameter int VERIFY       = 1,
   parameter int MAX_RETRY    = 2,
   parameter int BUSY_TIMEOUT = 65535
) (
   input  logic       clk_50,
   input  logic       rst_n,
   input  logic       start,
   output logic       done,
   output logic       error,
   output logic [7:0] err_index,
   output logic       request,
   output logic       WR,
   output logic [7:0] length,
   output logic [6:0] address,
   output logic [7:0] sub_address,
   output logic [7:0] txReg,
   input  logic       busy,
   input  logic [7:0] rxReg
);

   localparam logic [21:0] PWR_LAST  = 22'(PWR_WAIT - 1);
   localparam logic [21:0] GAP_LAST  = 22'(GAP_CYCLES - 1);
   localparam logic [15:0] TMO_LAST  = 16'(BUSY_TIMEOUT - 1);
   localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);
   localparam logic [7:0]  LAST_IDX  = 8'(ENTRIES - 1);

   cfg_state_t  state, state_n;
   cfg_state_t  gap_next, gap_next_n;
   logic [7:0]  index, index_n;
   logic [1:0]  retry, retry_n;
   logic [21:0] cnt, cnt_n;          // shared by PWR and GAP
   logic [15:0] tmo, tmo_n;
   logic [7:0]  rd_data, rd_data_n;
   logic        request_n, wr_n, done_n, error_n;
   logic [7:0]  err_index_n;
   logic [6:0]  address_n;
   logic [7:0]  sub_address_n, tx_n;
   logic        flag_err;
   cfg_entry_t  rom_entry;

   i2c_config_rom #(.ENTRIES(ENTRIES)) u_rom (
      .index (index),
      .entry (rom_entry)
   );

   assign length = XFER_LEN;

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_PWR;
         gap_next    <= ST_NEXT;
         index       <= '0;
         retry       <= '0;
         cnt         <= '0;
         tmo         <= '0;
         rd_data     <= '0;
         request     <= 1'b0;
         WR          <= 1'b0;
         address     <= '0;
         sub_address <= '0;
         txReg       <= '0;
         done        <= 1'b0;
         error       <= 1'b0;
         err_index   <= '0;
      end else begin
         state       <= state_n;
         gap_next    <= gap_next_n;
         index       <= index_n;
         retry       <= retry_n;
         cnt         <= cnt_n;
         tmo         <= tmo_n;
         rd_data     <= rd_data_n;
         request     <= request_n;
         WR          <= wr_n;
         address     <= address_n;
         sub_address <= sub_address_n;
         txReg       <= tx_n;
         done        <= done_n;
         error       <= error_n;
         err_index   <= err_index_n;
      end
   end

   always_comb begin
      state_n       = state;
      gap_next_n    = gap_next;
      index_n       = index;
      retry_n       = retry;
      cnt_n         = cnt;
      tmo_n         = tmo;
      rd_data_n     = rd_data;
      request_n     = request;
      wr_n          = WR;
      address_n     = address;
      sub_address_n = sub_address;
      tx_n          = txReg;
      done_n        = done;
      error_n       = error;
      err_index_n   = err_index;
      flag_err      = 1'b0;

      case (state)
         ST_PWR: begin
            if (cnt == PWR_LAST) begin
               cnt_n   = '0;
               state_n = ST_LOAD;
            end else begin
               cnt_n = cnt + 22'd1;
            end
         end

         ST_LOAD: begin
            address_n     = rom_entry.addr;
            sub_address_n = rom_entry.sub;
            tx_n          = rom_entry.data;
            wr_n          = 1'b1;
            request_n     = 1'b1;
            tmo_n         = '0;
            state_n       = ST_WREQ;
         end

         ST_WREQ, ST_RREQ: begin
            request_n = 1'b1;
            if (state == ST_RREQ) begin
               wr_n = 1'b0;
            end
            // Drop request as soon as the master acknowledges so it cannot
            // re-trigger when it returns to idle.
            if (busy) begin
               request_n = 1'b0;
               tmo_n     = '0;
               state_n   = (state == ST_WREQ) ? ST_WBUSY : ST_RBUSY;
            end else if (tmo == TMO_LAST) begin
               request_n = 1'b0;
               flag_err  = 1'b1;
               state_n   = ST_NEXT;
            end else begin
               tmo_n = tmo + 16'd1;
            end
         end

         ST_WBUSY, ST_RBUSY: begin
            if (!busy) begin
               cnt_n   = '0;
               state_n = ST_GAP;
               if (state == ST_RBUSY) begin
                  rd_data_n  = rxReg;
                  gap_next_n = ST_CHECK;
               end else begin
                  gap_next_n = (VERIFY != 0) ? ST_RREQ : ST_NEXT;
               end
            end else if (tmo == TMO_LAST) begin
               flag_err = 1'b1;
               state_n  = ST_NEXT;
            end else begin
               tmo_n = tmo + 16'd1;
            end
         end

         ST_CHECK: begin
            if (rd_data == rom_entry.data) begin
               state_n = ST_NEXT;
            end else if (retry < RETRY_MAX) begin
               retry_n = retry + 2'd1;
               state_n = ST_LOAD;
            end else begin
               flag_err = 1'b1;
               state_n  = ST_NEXT;
            end
         end

         ST_NEXT: begin
            retry_n = '0;
            if (index == LAST_IDX) begin
               done_n  = 1'b1;
               state_n = ST_DONE;
            end else begin
               index_n = index + 8'd1;
               state_n = ST_LOAD;
            end
         end

         ST_GAP: begin
            if (cnt == GAP_LAST) begin
               tmo_n   = '0;
               state_n = gap_next;
            end else begin
               cnt_n = cnt + 22'd1;
            end
         end

         ST_DONE: begin
            if (start) begin
               done_n  = 1'b0;
               error_n = 1'b0;
               index_n = '0;
               state_n = ST_LOAD;
            end
         end

         default: state_n = ST_PWR;
      endcase

      // Only the first failure since the last start is recorded in err_index.
      if (flag_err) begin
         error_n = 1'b1;
         if (!error) begin
            err_index_n = index;
         end
      end
   end

endmodule
